cpu_control_fsm: RTL and testbench
==================================

// Module: cpu_control_fsm
// PURPOSE
//  Multi-cycle control unit of the 16-bit CPU. Decodes the instruction held in the IR register and
//  sequences the bus select, ALU op and per-register load enables (EN) of the Reg instances below it.
//  Sits directly upstream of the register file, A/G ALU registers and IR; consumes IR output and Run.
// PARAMETERS
//  DW    16  datapath/instruction width
//  NREG  8   number of general registers R0..R7 (register index field is 3 bits)
// PORTS
//  CLK     in   1     CPU clock, all state on rising edge
//  reset   in   1     asynchronous, active-low reset (0 = reset)
//  Run     in   1     start request, sampled only in IDLE
//  Instr   in   DW    current IR contents: [15:13] opcode, [12:10] Rx, [9:7] Ry, rest ignored
//  IR_EN   out  1     load enable for IR (captures DIN)
//  R_EN    out  NREG  one-hot load enable for R0..R7
//  A_EN    out  1     load enable for ALU operand register A
//  G_EN    out  1     load enable for ALU result register G
//  Sel     out  4     bus source: 0-7 = R0-R7, 8 = DIN, 9 = G, others unused
//  ALU_op  out  2     00 add, 01 sub, 10 and, 11 unused
//  Done    out  1     one-cycle pulse in final cycle of each instruction
//  Busy    out  1     1 in any state other than IDLE
//  Icount  out  16    retired-instruction counter
// BEHAVIOUR
//  - State register: IDLE, T1, T2, T3 (2-bit). reset=0 -> IDLE immediately, Icount=0.
//  - While reset=0 all outputs forced 0 (IR_EN, R_EN, A_EN, G_EN, Sel, ALU_op, Done, Busy).
//  - Outputs are combinational from state, Instr and Run; no registered outputs except Icount.
//  - IDLE: IR_EN = Run; Run=1 -> T1 next edge; Run=0 stay IDLE. All other enables 0.
//  - T1 decode of Instr[15:13]:
//     000 mv : Sel=Ry, R_EN[Rx]=1, Done=1 -> IDLE
//     001 mvi: Sel=8 (DIN), R_EN[Rx]=1, Done=1 -> IDLE
//     010/011/100 add/sub/and: Sel=Rx, A_EN=1 -> T2
//     101-111 illegal: Done=1, no enables -> IDLE
//  - T2: Sel=Ry, G_EN=1, ALU_op = 00/01/10 for 010/011/100 -> T3
//  - T3: Sel=9 (G), R_EN[Rx]=1, Done=1 -> IDLE
//  - Latency: mv/mvi/illegal 2 cycles incl. IDLE fetch; ALU ops 4 cycles.
//  - Instr must be stable from T1 to end of instruction; IR_EN is 0 outside IDLE, so it is.
//  - Run ignored in T1..T3; Run held high gives back-to-back instructions (IDLE fetch each time).
//  - R_EN strictly one-hot or zero; never more than one of R_EN/A_EN/G_EN/IR_EN group active
//    except none. Rx==Ry legal (e.g. add R3,R3).
//  - Icount += 1 on each rising edge where Done=1; wraps 0xFFFF -> 0x0000. Illegal ops count.
//  - reset asserted mid-instruction: abandons it, no Done, Icount cleared; restarts in IDLE.
// TESTING
//  1. reset=0 at any state -> state IDLE, all outputs 0, Icount=0 within same cycle.
//  2. Run=1, Instr=0x0480 (mv R1,R1? Rx=1,Ry=1) -> IR_EN in IDLE, T1: Sel=1, R_EN=0x02, Done=1.
//  3. Instr=0x4680 (add Rx=1,Ry=5) -> T1 Sel=1 A_EN; T2 Sel=5 G_EN ALU_op=00; T3 Sel=9 R_EN=0x02 Done.
//  4. mvi Instr=0x3C00 (Rx=7) -> T1 Sel=8, R_EN=0x80, Done; Icount increments by 1.
//  5. Instr=0xE000 illegal -> T1 Done=1, all enables 0, back to IDLE; Icount increments.
//  6. Drop reset in T2 of sub -> no G_EN/Done seen; Icount=0; preload Icount=0xFFFF then Done -> 0.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU.
// Decodes the instruction held in IR and sequences the bus source select,
// the ALU operation and the per-register load enables. mv/mvi/illegal
// instructions finish in T1; add/sub/and take T1..T3.
//
// Handshake: Run is a level request that is sampled only in IDLE. While
// Run is high in IDLE, IR_EN captures DIN and the FSM moves to T1. Run is
// ignored in T1..T3. Done pulses for exactly one cycle, in the final cycle
// of every instruction, and Icount counts retired instructions on that edge.
module cpu_control_fsm #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            Run,
  input  logic [DW-1:0]   Instr,
  output logic            IR_EN,
  output logic [NREG-1:0] R_EN,
  output logic            A_EN,
  output logic            G_EN,
  output logic [3:0]      Sel,
  output logic [1:0]      ALU_op,
  output logic            Done,
  output logic            Busy,
  output logic [15:0]     Icount,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  localparam logic [3:0] SEL_DIN = 4'd8;
  localparam logic [3:0] SEL_G   = 4'd9;

  state_t state, state_next;
  logic [15:0] icount_q;

  // Instruction fields; everything below Ry is ignored.
  logic [2:0] opcode, rx, ry;
  assign opcode = Instr[DW-1 -: 3];
  assign rx     = Instr[DW-4 -: 3];
  assign ry     = Instr[DW-7 -: 3];

  // One-hot enable for the destination register Rx.
  logic [NREG-1:0] rx_onehot;
  assign rx_onehot = NREG'(1) << rx;

  // State register; an asserted reset abandons any instruction in flight.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and combinational control outputs, all forced to 0 in reset.
  always_comb begin
    state_next = state;
    IR_EN      = 1'b0;
    R_EN       = '0;
    A_EN       = 1'b0;
    G_EN       = 1'b0;
    Sel        = 4'd0;
    ALU_op     = 2'b00;
    Done       = 1'b0;
    Busy       = (state != IDLE);

    unique case (state)
      IDLE: begin
        IR_EN = Run;
        if (Run) state_next = T1;
      end
      T1: begin
        unique case (opcode)
          OP_MV: begin
            Sel        = {1'b0, ry};
            R_EN       = rx_onehot;
            Done       = 1'b1;
            state_next = IDLE;
          end
          OP_MVI: begin
            Sel        = SEL_DIN;
            R_EN       = rx_onehot;
            Done       = 1'b1;
            state_next = IDLE;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            Sel        = {1'b0, rx};
            A_EN       = 1'b1;
            state_next = T2;
          end
          default: begin
            // Illegal opcode: retire with no side effects.
            Done       = 1'b1;
            state_next = IDLE;
          end
        endcase
      end
      T2: begin
        Sel  = {1'b0, ry};
        G_EN = 1'b1;
        case (opcode)
          OP_SUB:  ALU_op = 2'b01;
          OP_AND:  ALU_op = 2'b10;
          default: ALU_op = 2'b00;
        endcase
        state_next = T3;
      end
      T3: begin
        Sel        = SEL_G;
        R_EN       = rx_onehot;
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Reset is asynchronous, so the outputs must drop in the same cycle too.
    if (!reset) begin
      IR_EN  = 1'b0;
      R_EN   = '0;
      A_EN   = 1'b0;
      G_EN   = 1'b0;
      Sel    = 4'd0;
      ALU_op = 2'b00;
      Done   = 1'b0;
      Busy   = 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally at 0xFFFF.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)    icount_q <= 16'd0;
    else if (Done) icount_q <= icount_q + 16'd1;
  end

  assign Icount    = icount_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: inputs change and outputs are
// sampled on the falling edge, away from the rising edge that updates state.
module tb_cpu_control_fsm;

  logic        CLK;
  logic        reset;
  logic        Run;
  logic [15:0] Instr;
  logic        IR_EN;
  logic [7:0]  R_EN;
  logic        A_EN;
  logic        G_EN;
  logic [3:0]  Sel;
  logic [1:0]  ALU_op;
  logic        Done;
  logic        Busy;
  logic [15:0] Icount;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  cpu_control_fsm #(.DW(16), .NREG(8)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .Run       (Run),
    .Instr     (Instr),
    .IR_EN     (IR_EN),
    .R_EN      (R_EN),
    .A_EN      (A_EN),
    .G_EN      (G_EN),
    .Sel       (Sel),
    .ALU_op    (ALU_op),
    .Done      (Done),
    .Busy      (Busy),
    .Icount    (Icount),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one full cycle, ending on the falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Checks the full control word in one go.
  task automatic check_ctrl(input string tag, input logic ir, input logic [7:0] r,
                            input logic a, input logic g, input logic [3:0] s,
                            input logic [1:0] op, input logic d, input logic b);
    check({tag, ".IR_EN"},  32'(IR_EN),  32'(ir));
    check({tag, ".R_EN"},   32'(R_EN),   32'(r));
    check({tag, ".A_EN"},   32'(A_EN),   32'(a));
    check({tag, ".G_EN"},   32'(G_EN),   32'(g));
    check({tag, ".Sel"},    32'(Sel),    32'(s));
    check({tag, ".ALU_op"}, 32'(ALU_op), 32'(op));
    check({tag, ".Done"},   32'(Done),   32'(d));
    check({tag, ".Busy"},   32'(Busy),   32'(b));
  endtask

  // Present an instruction in IDLE with Run high and check the fetch cycle.
  task automatic fetch(input string tag, input logic [15:0] ins);
    Instr = ins;
    Run   = 1'b1;
    #1;
    check({tag, ".idle_state"}, 32'(dbg_state), 32'd0);
    check_ctrl({tag, ".idle"}, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held low with Run high: every output must stay 0.
    reset = 1'b0;
    Run   = 1'b1;
    Instr = 16'h4680;
    @(negedge CLK);
    step();
    check("rst.state",  32'(dbg_state), 32'd0);
    check("rst.icount", 32'(Icount),    32'd0);
    check_ctrl("rst", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    reset = 1'b1;

    // Run low in IDLE: nothing happens.
    Run = 1'b0;
    #1;
    check_ctrl("idle_norun", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    step();
    check("idle_norun.state", 32'(dbg_state), 32'd0);

    // mv R1,R1
    fetch("mv", 16'h0480);
    step();
    check_ctrl("mv.t1", 1'b0, 8'h02, 1'b0, 1'b0, 4'd1, 2'b00, 1'b1, 1'b1);
    step();
    check("mv.icount", 32'(Icount), 32'd1);

    // add R1,R5 (back-to-back: Run stays high)
    fetch("add", 16'h4680);
    step();
    check_ctrl("add.t1", 1'b0, 8'h00, 1'b1, 1'b0, 4'd1, 2'b00, 1'b0, 1'b1);
    step();
    check_ctrl("add.t2", 1'b0, 8'h00, 1'b0, 1'b1, 4'd5, 2'b00, 1'b0, 1'b1);
    step();
    check_ctrl("add.t3", 1'b0, 8'h02, 1'b0, 1'b0, 4'd9, 2'b00, 1'b1, 1'b1);
    step();
    check("add.icount", 32'(Icount), 32'd2);

    // mvi R7
    fetch("mvi", 16'h3C00);
    step();
    check_ctrl("mvi.t1", 1'b0, 8'h80, 1'b0, 1'b0, 4'd8, 2'b00, 1'b1, 1'b1);
    step();
    check("mvi.icount", 32'(Icount), 32'd3);

    // illegal opcode 111
    fetch("ill", 16'hE000);
    step();
    check_ctrl("ill.t1", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b1);
    step();
    check("ill.icount", 32'(Icount), 32'd4);
    check("ill.state",  32'(dbg_state), 32'd0);

    // and R3,R3 (Rx == Ry)
    fetch("and", 16'h8D80);
    step();
    check_ctrl("and.t1", 1'b0, 8'h00, 1'b1, 1'b0, 4'd3, 2'b00, 1'b0, 1'b1);
    step();
    check_ctrl("and.t2", 1'b0, 8'h00, 1'b0, 1'b1, 4'd3, 2'b10, 1'b0, 1'b1);
    step();
    check_ctrl("and.t3", 1'b0, 8'h08, 1'b0, 1'b0, 4'd9, 2'b00, 1'b1, 1'b1);
    step();
    check("and.icount", 32'(Icount), 32'd5);

    // sub R2,R3, reset dropped in T2
    fetch("sub", 16'h6980);
    step();
    check_ctrl("sub.t1", 1'b0, 8'h00, 1'b1, 1'b0, 4'd2, 2'b00, 1'b0, 1'b1);
    step();
    check("sub.t2_state", 32'(dbg_state), 32'd2);
    check("sub.t2_aluop", 32'(ALU_op),    32'd1);
    reset = 1'b0;
    #1;
    check("sub.rst_state",  32'(dbg_state), 32'd0);
    check("sub.rst_icount", 32'(Icount),    32'd0);
    check_ctrl("sub.rst", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    step();
    check_ctrl("sub.rst_hold", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    check("sub.rst_hold_icount", 32'(Icount), 32'd0);
    Run   = 1'b0;
    reset = 1'b1;
    step();
    check("sub.after_state", 32'(dbg_state), 32'd0);

    // Counter wrap: preload 0xFFFF, then retire one mvi.
    force dut.icount_q = 16'hFFFF;
    #1;
    release dut.icount_q;
    #1;
    check("wrap.preload", 32'(Icount), 32'hFFFF);
    @(negedge CLK);
    fetch("wrap", 16'h3C00);
    step();
    check("wrap.t1_done", 32'(Done), 32'd1);
    Run = 1'b0;
    step();
    check("wrap.icount", 32'(Icount), 32'd0);
    check("wrap.state",  32'(dbg_state), 32'd0);

    // Report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net: a stalled run still reports and ends.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
